// File: rtl/eth_link_supervisor.sv
// Link bring-up supervisor for the 10G QSFP0 lane: sequences the transceiver wizard
// reset, qualifies PCS block lock into link_up, and keeps retry / lock-loss counters.
module eth_link_supervisor #(
   parameter int RESET_PULSE_CYCLES  = 16,
   parameter int DONE_TIMEOUT_CYCLES = 1250000,
   parameter int LOCK_TIMEOUT_CYCLES = 12500000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int SYNC_STAGES         = 2
) (
   input  logic        clk_125mhz_int,
   input  logic        gt_tx_reset,
   input  logic        enable,
   input  logic        gt_reset_tx_done,
   input  logic        gt_reset_rx_done,
   input  logic        rx_block_lock,
   input  logic        rx_high_ber,
   output logic        gt_reset_all,
   output logic        link_up,
   output logic [2:0]  state,
   output logic [7:0]  retry_count,
   output logic [15:0] lock_loss_count
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = max2(max2(RESET_PULSE_CYCLES, DONE_TIMEOUT_CYCLES),
                                 max2(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));
   localparam int TW = $clog2(MAX_CYC) + 1;
   localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;

   localparam logic [TW-1:0] PULSE_LAST = TW'(RESET_PULSE_CYCLES - 1);
   localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET     = 3'd1,
      WAIT_DONE = 3'd2,
      WAIT_LOCK = 3'd3,
      UP        = 3'd4
   } state_t;

   // Synchronizer bit order: {hber, lock, rx_done, tx_done}
   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   state_t                      state_q, state_d;
   logic [TW-1:0]               timer_q, timer_d;
   logic [SW-1:0]               stable_q, stable_d;
   logic [7:0]                  retry_count_q, retry_count_d;
   logic [15:0]                 lock_loss_count_q, lock_loss_count_d;
   logic                        gt_reset_all_q, gt_reset_all_d;
   logic                        link_up_q, link_up_d;

   logic d_tx, d_rx, lock, hber, dones, good;
   logic retry_inc, loss_inc;

   always_comb begin
      sync_d[0] = {rx_high_ber, rx_block_lock, gt_reset_rx_done, gt_reset_tx_done};
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   assign d_tx  = sync_q[SYNC_STAGES-1][0];
   assign d_rx  = sync_q[SYNC_STAGES-1][1];
   assign lock  = sync_q[SYNC_STAGES-1][2];
   assign hber  = sync_q[SYNC_STAGES-1][3];
   assign dones = d_tx & d_rx;
   assign good  = lock & ~hber;

   always_comb begin
      state_d   = state_q;
      stable_d  = '0;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RESET;
         end
         RESET: begin
            if (timer_q == PULSE_LAST) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (dones) begin
               state_d = WAIT_LOCK;
            end else if (timer_q == DONE_LAST) begin
               state_d   = RESET;
               retry_inc = 1'b1;
            end
         end
         WAIT_LOCK: begin
            stable_d = good ? stable_q + SW'(1) : '0;
            // Success is checked first so it beats a same-cycle timeout.
            if (good && stable_q == STABLE_LAST) begin
               state_d = UP;
            end else if (!dones || timer_q == LOCK_LAST) begin
               state_d   = RESET;
               retry_inc = 1'b1;
            end
         end
         UP: begin
            if (!good) begin
               loss_inc = 1'b1;
               state_d  = dones ? WAIT_LOCK : RESET;
            end else if (!dones) begin
               loss_inc = 1'b1;
               state_d  = RESET;
            end
         end
         default: state_d = IDLE;
      endcase

      // Disable overrides everything and leaves the counters untouched.
      if (!enable) begin
         state_d   = IDLE;
         stable_d  = '0;
         retry_inc = 1'b0;
         loss_inc  = 1'b0;
      end

      retry_count_d     = (retry_inc && retry_count_q != 8'hFF) ?
                          retry_count_q + 8'd1 : retry_count_q;
      lock_loss_count_d = (loss_inc && lock_loss_count_q != 16'hFFFF) ?
                          lock_loss_count_q + 16'd1 : lock_loss_count_q;
      timer_d           = (state_d != state_q) ? '0 : timer_q + TW'(1);
      gt_reset_all_d    = (state_d == IDLE) || (state_d == RESET);
      link_up_d         = (state_d == UP);
   end

   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         sync_q            <= '0;
         state_q           <= IDLE;
         timer_q           <= '0;
         stable_q          <= '0;
         retry_count_q     <= '0;
         lock_loss_count_q <= '0;
         gt_reset_all_q    <= 1'b1;
         link_up_q         <= 1'b0;
      end else begin
         sync_q            <= sync_d;
         state_q           <= state_d;
         timer_q           <= timer_d;
         stable_q          <= stable_d;
         retry_count_q     <= retry_count_d;
         lock_loss_count_q <= lock_loss_count_d;
         gt_reset_all_q    <= gt_reset_all_d;
         link_up_q         <= link_up_d;
      end
   end

   assign gt_reset_all    = gt_reset_all_q;
   assign link_up         = link_up_q;
   assign state           = state_q;
   assign retry_count     = retry_count_q;
   assign lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Directed bench for eth_link_supervisor with small timing parameters; expected output
// snapshots go through a scoreboard queue and are compared with immediate assertions.
module tb_eth_link_supervisor;

   logic        clk_125mhz_int = 1'b0;
   logic        gt_tx_reset;
   logic        enable;
   logic        gt_reset_tx_done;
   logic        gt_reset_rx_done;
   logic        rx_block_lock;
   logic        rx_high_ber;
   logic        gt_reset_all;
   logic        link_up;
   logic [2:0]  state;
   logic [7:0]  retry_count;
   logic [15:0] lock_loss_count;

   int checks = 0;
   int errors = 0;
   int n;

   typedef struct {
      string       tag;
      logic [28:0] v;
   } exp_t;
   exp_t sb[$];

   eth_link_supervisor #(
      .RESET_PULSE_CYCLES  (4),
      .DONE_TIMEOUT_CYCLES (20),
      .LOCK_TIMEOUT_CYCLES (50),
      .LOCK_STABLE_CYCLES  (8),
      .SYNC_STAGES         (2)
   ) dut (
      .clk_125mhz_int   (clk_125mhz_int),
      .gt_tx_reset      (gt_tx_reset),
      .enable           (enable),
      .gt_reset_tx_done (gt_reset_tx_done),
      .gt_reset_rx_done (gt_reset_rx_done),
      .rx_block_lock    (rx_block_lock),
      .rx_high_ber      (rx_high_ber),
      .gt_reset_all     (gt_reset_all),
      .link_up          (link_up),
      .state            (state),
      .retry_count      (retry_count),
      .lock_loss_count  (lock_loss_count)
   );

   always #4 clk_125mhz_int = ~clk_125mhz_int;

   task automatic tick();
      @(posedge clk_125mhz_int);
      #1;
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected snapshot {state, gt_reset_all, link_up, retry_count, lock_loss_count}
   task automatic push_exp(input string tag, input logic [2:0] st, input logic gra,
                           input logic lu, input logic [7:0] rc, input logic [15:0] lc);
      exp_t e;
      e.tag = tag;
      e.v   = {st, gra, lu, rc, lc};
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t        e;
      logic [28:0] got;
      got = {state, gt_reset_all, link_up, retry_count, lock_loss_count};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty got %h expected an entry", got);
      end else begin
         e = sb.pop_front();
         assert (got === e.v) else begin
            errors++;
            $error("FAIL %s got st=%0d gra=%0b lu=%0b rc=%0d lc=%0d expected st=%0d gra=%0b lu=%0b rc=%0d lc=%0d",
                   e.tag, got[28:26], got[25], got[24], got[23:16], got[15:0],
                   e.v[28:26], e.v[25], e.v[24], e.v[23:16], e.v[15:0]);
         end
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st, input logic gra,
                             input logic lu, input logic [7:0] rc, input logic [15:0] lc);
      push_exp(tag, st, gra, lu, rc, lc);
      check_out();
   endtask

   // Ticks until state==target; returns tick count, or -1 when the bound expires.
   task automatic wait_state(input logic [2:0] target, input int maxc, output int cnt);
      int i;
      i   = 0;
      cnt = -1;
      while (cnt < 0 && i < maxc) begin
         i++;
         tick();
         if (state === target) cnt = i;
      end
   endtask

   initial begin
      gt_tx_reset      = 1'b1;
      enable           = 1'b0;
      gt_reset_tx_done = 1'b0;
      gt_reset_rx_done = 1'b0;
      rx_block_lock    = 1'b0;
      rx_high_ber      = 1'b0;
      tick();
      tick();
      expect_out("reset_state", 3'd0, 1'b1, 1'b0, 8'd0, 16'd0);
      gt_tx_reset = 1'b0;
      tick();
      expect_out("idle_disabled", 3'd0, 1'b1, 1'b0, 8'd0, 16'd0);

      // Clean bring-up
      enable = 1'b1;
      tick();
      expect_out("enter_reset", 3'd1, 1'b1, 1'b0, 8'd0, 16'd0);
      wait_state(3'd2, 10, n);
      chk_int("reset_pulse_len", n, 4);
      expect_out("wait_done", 3'd2, 1'b0, 1'b0, 8'd0, 16'd0);
      gt_reset_tx_done = 1'b1;
      gt_reset_rx_done = 1'b1;
      wait_state(3'd3, 10, n);
      chk_int("done_sync_latency", n, 3);
      rx_block_lock = 1'b1;
      wait_state(3'd4, 30, n);
      chk_int("lock_to_up", n, 10);
      expect_out("up_first", 3'd4, 1'b0, 1'b1, 8'd0, 16'd0);

      // High-BER pulse in UP
      rx_high_ber = 1'b1;
      tick();
      tick();
      expect_out("hber_not_yet", 3'd4, 1'b0, 1'b1, 8'd0, 16'd0);
      tick();
      rx_high_ber = 1'b0;
      expect_out("hber_drop", 3'd3, 1'b0, 1'b0, 8'd0, 16'd1);
      wait_state(3'd4, 30, n);
      chk_int("hber_recover", n, 10);
      expect_out("up_again", 3'd4, 1'b0, 1'b1, 8'd0, 16'd1);

      // Done drop in UP
      gt_reset_rx_done = 1'b0;
      gt_reset_tx_done = 1'b0;
      wait_state(3'd1, 10, n);
      chk_int("done_drop_latency", n, 3);
      expect_out("done_drop", 3'd1, 1'b1, 1'b0, 8'd0, 16'd2);

      // Done timeout loops up to retry saturation
      for (int k = 1; k <= 300; k++) begin
         wait_state(3'd2, 30, n);
         chk_int("loop_reset_len", n, 4);
         wait_state(3'd1, 40, n);
         chk_int("loop_done_timeout", n, 20);
         expect_out("loop_retry", 3'd1, 1'b1, 1'b0, (k > 255) ? 8'd255 : 8'(k), 16'd2);
      end

      // Async reset mid-UP
      gt_reset_tx_done = 1'b1;
      gt_reset_rx_done = 1'b1;
      wait_state(3'd4, 100, n);
      chk_int("reach_up_sat", (n > 0) ? 1 : 0, 1);
      expect_out("up_sat", 3'd4, 1'b0, 1'b1, 8'd255, 16'd2);
      #2 gt_tx_reset = 1'b1;
      #1 expect_out("async_reset", 3'd0, 1'b1, 1'b0, 8'd0, 16'd0);
      rx_block_lock = 1'b0;
      tick();
      gt_tx_reset = 1'b0;
      tick();
      expect_out("post_reset", 3'd1, 1'b1, 1'b0, 8'd0, 16'd0);

      // Lock toggling in WAIT_LOCK never qualifies; lock timeout fires
      wait_state(3'd3, 20, n);
      chk_int("reach_wait_lock", (n > 0) ? 1 : 0, 1);
      n = -1;
      for (int i = 0; i < 60; i++) begin
         if (n < 0) begin
            rx_block_lock = (i % 5) != 4;
            tick();
            if (state === 3'd1) n = i + 1;
         end
      end
      chk_int("lock_timeout", n, 50);
      expect_out("lock_timeout_state", 3'd1, 1'b1, 1'b0, 8'd1, 16'd0);

      // enable=0 during RESET and during UP
      enable = 1'b0;
      tick();
      expect_out("disable_in_reset", 3'd0, 1'b1, 1'b0, 8'd1, 16'd0);
      rx_block_lock = 1'b1;
      enable = 1'b1;
      wait_state(3'd4, 100, n);
      chk_int("reach_up_final", (n > 0) ? 1 : 0, 1);
      expect_out("up_final", 3'd4, 1'b0, 1'b1, 8'd1, 16'd0);
      enable = 1'b0;
      tick();
      expect_out("disable_in_up", 3'd0, 1'b1, 1'b0, 8'd1, 16'd0);
      tick();
      expect_out("idle_hold", 3'd0, 1'b1, 1'b0, 8'd1, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
